vga_rx_decoder: RTL and testbench

- Receiving end of the VGA output interface: samples hs/vs/blank_n/RGB as driven by our VGA timing generator and recovers active-pixel coordinates.
- Measures active pixels per line and active lines per frame against the expected geometry, and runs a lock state machine.
- Sits on the capture/loopback side: the bench monitor in simulation, and an on-chip self-check path in hardware builds.

---
 rtl/vga_rx_pkg.sv | 7 +
 rtl/vga_rx_crc16.sv | 14 +
 rtl/vga_rx_decoder.sv | 166 ++++++++++++++++
 tb/tb_vga_rx_decoder.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_rx_pkg.sv
// vga_rx_pkg: shared types and constants for the VGA receive decoder.
package vga_rx_pkg;
  typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED} lock_state_e;
  typedef logic [23:0] pixel_t;
  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;
endpackage

// File: rtl/vga_rx_crc16.sv
// vga_rx_crc16: CRC-16-CCITT update over one 24-bit pixel, MSB first.
module vga_rx_crc16
  import vga_rx_pkg::*;
(
  input  logic [15:0] crc_in,
  input  pixel_t      data,
  output logic [15:0] crc_out
);
  always_comb begin
    crc_out = crc_in;
    for (int i = 23; i >= 0; i--)
      crc_out = {crc_out[14:0], 1'b0} ^ ((crc_out[15] ^ data[i]) ? CRC_POLY : 16'h0000);
  end
endmodule

// File: rtl/vga_rx_decoder.sv
// vga_rx_decoder: recovers pixel coordinates from VGA hs/vs/blank_n, measures geometry, runs a lock FSM.
// Define VGA_RX_CRC_EN to add the per-frame CRC-16 output frame_crc.
module vga_rx_decoder
  import vga_rx_pkg::*;
#(
  parameter int unsigned H_ACTIVE        = 640,
  parameter int unsigned V_ACTIVE        = 480,
  parameter int unsigned CNT_W           = 10,
  parameter bit          SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             pix_en,
  input  logic             vga_hs,
  input  logic             vga_vs,
  input  logic             vga_blank_n,
  input  logic [23:0]      vga_rgb,
  output logic             pix_valid,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  output logic [23:0]      pix_rgb,
  output logic             frame_done,
  output logic [CNT_W-1:0] line_px,
  output logic [CNT_W-1:0] frame_lines,
  output logic             locked,
  output logic             timing_err
`ifdef VGA_RX_CRC_EN
  ,
  output logic [15:0]      frame_crc
`endif
);
  localparam logic [CNT_W-1:0] H_EXP   = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_EXP   = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic hs_a, vs_a;
  logic smp_q, smp_d, hs_q, hs_d, hs_p_q, hs_p_d, vs_q, vs_d, vs_p_q, vs_p_d, blank_q, blank_d;
  pixel_t rgb_q, rgb_d;
  logic hs_edge, vs_edge, act, line_close, line_bad, frame_bad, ok_h, lock_fail;
  logic [CNT_W-1:0] x_base, y_h;
  logic [CNT_W-1:0] x_cnt_q, x_cnt_d, y_cnt_q, y_cnt_d;
  lock_state_e state_q, state_d;
  logic frame_ok_q, frame_ok_d;
  logic pix_valid_q, pix_valid_d, frame_done_q, frame_done_d, locked_q, locked_d, timing_err_q, timing_err_d;
  logic [CNT_W-1:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d, line_px_q, line_px_d, frame_lines_q, frame_lines_d;
  pixel_t pix_rgb_q, pix_rgb_d;

  assign hs_a = SYNC_ACTIVE_LOW ? ~vga_hs : vga_hs;
  assign vs_a = SYNC_ACTIVE_LOW ? ~vga_vs : vga_vs;

  always_comb begin
    smp_d   = pix_en;
    hs_d    = pix_en ? hs_a : hs_q;
    hs_p_d  = pix_en ? hs_q : hs_p_q;
    vs_d    = pix_en ? vs_a : vs_q;
    vs_p_d  = pix_en ? vs_q : vs_p_q;
    blank_d = pix_en ? vga_blank_n : blank_q;
    rgb_d   = pix_en ? vga_rgb : rgb_q;
    hs_edge = smp_q & hs_q & ~hs_p_q;
    vs_edge = smp_q & vs_q & ~vs_p_q;
    act     = smp_q & blank_q;
    // the line is closed before any vs action in the same sample
    line_close = hs_edge & (x_cnt_q != '0);
    line_bad   = line_close & ((x_cnt_q != H_EXP) | (x_cnt_q == CNT_MAX));
    x_base     = hs_edge ? '0 : x_cnt_q;
    x_cnt_d    = (act && x_base != CNT_MAX) ? x_base + 1'b1 : x_base;
    y_h        = (line_close && y_cnt_q != CNT_MAX) ? y_cnt_q + 1'b1 : y_cnt_q;
    y_cnt_d    = vs_edge ? '0 : y_h;
    frame_bad  = (y_h != V_EXP) | (y_h == CNT_MAX);
    ok_h       = frame_ok_q & ~line_bad;
    frame_ok_d = vs_edge | ok_h;
    lock_fail  = (state_q == LOCKED) & (line_bad | (vs_edge & frame_bad));
    state_d    = lock_fail ? ACQUIRE :
                 !vs_edge ? state_q :
                 (state_q == UNLOCKED) ? ACQUIRE :
                 (state_q == ACQUIRE) ? ((ok_h & ~frame_bad) ? LOCKED : ACQUIRE) : state_q;
    pix_valid_d   = act;
    pix_x_d       = act ? x_base : pix_x_q;
    pix_y_d       = act ? y_cnt_d : pix_y_q;
    pix_rgb_d     = act ? rgb_q : pix_rgb_q;
    frame_done_d  = vs_edge;
    line_px_d     = line_close ? x_cnt_q : line_px_q;
    frame_lines_d = vs_edge ? y_h : frame_lines_q;
    locked_d      = state_d == LOCKED;
    timing_err_d  = lock_fail;
  end

  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      smp_q         <= 1'b0;
      hs_q          <= 1'b0;
      hs_p_q        <= 1'b0;
      vs_q          <= 1'b0;
      vs_p_q        <= 1'b0;
      blank_q       <= 1'b0;
      rgb_q         <= '0;
      x_cnt_q       <= '0;
      y_cnt_q       <= '0;
      state_q       <= UNLOCKED;
      frame_ok_q    <= 1'b0;
      pix_valid_q   <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      pix_rgb_q     <= '0;
      frame_done_q  <= 1'b0;
      line_px_q     <= '0;
      frame_lines_q <= '0;
      locked_q      <= 1'b0;
      timing_err_q  <= 1'b0;
    end else begin
      smp_q         <= smp_d;
      hs_q          <= hs_d;
      hs_p_q        <= hs_p_d;
      vs_q          <= vs_d;
      vs_p_q        <= vs_p_d;
      blank_q       <= blank_d;
      rgb_q         <= rgb_d;
      x_cnt_q       <= x_cnt_d;
      y_cnt_q       <= y_cnt_d;
      state_q       <= state_d;
      frame_ok_q    <= frame_ok_d;
      pix_valid_q   <= pix_valid_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      pix_rgb_q     <= pix_rgb_d;
      frame_done_q  <= frame_done_d;
      line_px_q     <= line_px_d;
      frame_lines_q <= frame_lines_d;
      locked_q      <= locked_d;
      timing_err_q  <= timing_err_d;
    end

  assign pix_valid   = pix_valid_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign pix_rgb     = pix_rgb_q;
  assign frame_done  = frame_done_q;
  assign line_px     = line_px_q;
  assign frame_lines = frame_lines_q;
  assign locked      = locked_q;
  assign timing_err  = timing_err_q;

`ifdef VGA_RX_CRC_EN
  logic [15:0] crc_q, crc_d, crc_base, crc_nx, frame_crc_q, frame_crc_d;

  vga_rx_crc16 u_crc (.crc_in(crc_base), .data(rgb_q), .crc_out(crc_nx));

  // a pixel sampled together with vs belongs to the new frame
  always_comb begin
    crc_base    = vs_edge ? CRC_INIT : crc_q;
    crc_d       = act ? crc_nx : crc_base;
    frame_crc_d = vs_edge ? crc_q : frame_crc_q;
  end

  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      crc_q       <= CRC_INIT;
      frame_crc_q <= '0;
    end else begin
      crc_q       <= crc_d;
      frame_crc_q <= frame_crc_d;
    end

  assign frame_crc = frame_crc_q;
`endif
endmodule

// File: tb/tb_vga_rx_decoder.sv
// tb_vga_rx_decoder: table-driven frame checks plus latency, reset and simultaneous-edge sequences.
module tb_vga_rx_decoder;
  localparam int H = 16;
  localparam int V = 12;
  localparam int W = 10;
  localparam int N = 1024;

  logic clk = 1'b0;
  logic resetn, pix_en, vga_hs, vga_vs, vga_blank_n;
  logic [23:0] vga_rgb;
  logic pix_valid, frame_done, locked, timing_err;
  logic [W-1:0] pix_x, pix_y, line_px, frame_lines;
  logic [23:0] pix_rgb;
`ifdef VGA_RX_CRC_EN
  logic [15:0] frame_crc, crc_at_fd;
`endif

  vga_rx_decoder #(.H_ACTIVE(H), .V_ACTIVE(V), .CNT_W(W), .SYNC_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .resetn(resetn), .pix_en(pix_en), .vga_hs(vga_hs), .vga_vs(vga_vs),
    .vga_blank_n(vga_blank_n), .vga_rgb(vga_rgb), .pix_valid(pix_valid), .pix_x(pix_x),
    .pix_y(pix_y), .pix_rgb(pix_rgb), .frame_done(frame_done), .line_px(line_px),
    .frame_lines(frame_lines), .locked(locked), .timing_err(timing_err)
`ifdef VGA_RX_CRC_EN
    , .frame_crc(frame_crc)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {logic [W-1:0] x; logic [W-1:0] y; logic [23:0] rgb;} pix_t;
  typedef struct {int nl; int sh; bit simul; bit solid; logic [23:0] col;
                  int fl; int lpx; bit lk; int te; bit tefd; int telpx;} vec_t;

  pix_t exp_a[N];
  pix_t got[N];
  int exp_n = 0, got_n = 0, rd = 0;
  int checks = 0, errors = 0;
  int fd_cnt = 0, te_cnt = 0;
  bit trk = 0;
  logic [W-1:0] fl_at_fd, lx, ly, te_lpx;
  logic lk_at_fd, te_at_fd;

  always @(negedge clk) begin
    if (resetn && pix_valid) begin
      lx = pix_x;
      ly = pix_y;
      if (trk) begin
        got[got_n % N] = '{pix_x, pix_y, pix_rgb};
        got_n++;
      end
    end
    if (resetn && frame_done) begin
      fd_cnt++;
      fl_at_fd = frame_lines;
      lk_at_fd = locked;
      te_at_fd = timing_err;
`ifdef VGA_RX_CRC_EN
      crc_at_fd = frame_crc;
`endif
    end
    if (resetn && timing_err) begin
      te_cnt++;
      te_lpx = line_px;
    end
  end

  task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, a, e);
    end
  endtask

  task automatic px(input bit hs, input bit vs, input bit bl, input logic [23:0] c, input int x, input int y);
    @(negedge clk);
    vga_hs = ~hs;
    vga_vs = ~vs;
    vga_blank_n = bl;
    vga_rgb = c;
    pix_en = 1'b1;
    if (bl && trk) begin
      exp_a[exp_n % N] = '{W'(x), W'(y), c};
      exp_n++;
    end
    @(negedge clk);
    pix_en = 1'b0;
  endtask

  // vm: 0 = vs idle, 1 = vs held for the whole line, 2 = vs asserts with hs
  task automatic line(input int na, input int vm, input int y, input bit solid, input logic [23:0] col);
    for (int p = 0; p < na; p++) px(1'b0, vm == 1, 1'b1, solid ? col : {8'(p), 8'(y), 8'h5A}, p, y);
    px(1'b0, vm == 1, 1'b0, 24'h0, 0, 0);
    px(1'b1, vm != 0, 1'b0, 24'h0, 0, 0);
    px(1'b1, vm != 0, 1'b0, 24'h0, 0, 0);
    px(1'b0, vm != 0, 1'b0, 24'h0, 0, 0);
  endtask

  task automatic frame(input int nl, input int sh, input bit simul, input bit solid, input logic [23:0] col);
    line(0, 0, 0, 1'b0, 24'h0);
    for (int i = 0; i < nl; i++) line((i == sh) ? H - 1 : H, (simul && i == nl - 1) ? 2 : 0, i, solid, col);
    if (!simul) line(0, 0, 0, 1'b0, 24'h0);
    line(0, 1, 0, 1'b0, 24'h0);
    line(0, 1, 0, 1'b0, 24'h0);
  endtask

  task automatic cmp_pixels();
    chk("px_count", 128'(got_n), 128'(exp_n));
    while (rd < got_n) begin
      chk($sformatf("pix%0d", rd), {got[rd % N].x, got[rd % N].y, got[rd % N].rgb},
          {exp_a[rd % N].x, exp_a[rd % N].y, exp_a[rd % N].rgb});
      rd++;
    end
  endtask

`ifdef VGA_RX_CRC_EN
  function automatic logic [15:0] crc_ref(input logic [23:0] c, input int n);
    logic [15:0] r;
    r = 16'hFFFF;
    for (int k = 0; k < n; k++)
      for (int i = 23; i >= 0; i--) r = {r[14:0], 1'b0} ^ ((r[15] ^ c[i]) ? 16'h1021 : 16'h0000);
    return r;
  endfunction
`endif

  vec_t tbl[13];

  initial begin
    int fd0, te0;
    tbl[0]  = '{V, -1, 1'b0, 1'b0, 24'h0, V, H, 1'b1, 0, 1'b0, 0};
    tbl[1]  = '{V, -1, 1'b0, 1'b0, 24'h0, V, H, 1'b1, 0, 1'b0, 0};
    tbl[2]  = '{V, -1, 1'b0, 1'b0, 24'h0, V, H, 1'b1, 0, 1'b0, 0};
    tbl[3]  = '{V, 5, 1'b0, 1'b0, 24'h0, V, H, 1'b0, 1, 1'b0, H - 1};
    tbl[4]  = '{V, -1, 1'b0, 1'b0, 24'h0, V, H, 1'b1, 0, 1'b0, 0};
    tbl[5]  = '{V + 1, -1, 1'b0, 1'b0, 24'h0, V + 1, H, 1'b0, 1, 1'b1, H};
    tbl[6]  = '{V, -1, 1'b0, 1'b0, 24'h0, V, H, 1'b1, 0, 1'b0, 0};
    tbl[7]  = '{V, -1, 1'b1, 1'b0, 24'h0, V, H, 1'b1, 0, 1'b0, 0};
    tbl[8]  = '{V, -1, 1'b0, 1'b0, 24'h0, V, H, 1'b1, 0, 1'b0, 0};
    tbl[9]  = '{V, -1, 1'b0, 1'b1, 24'h000000, V, H, 1'b1, 0, 1'b0, 0};
    tbl[10] = '{V, -1, 1'b0, 1'b1, 24'hFFFFFF, V, H, 1'b1, 0, 1'b0, 0};
    tbl[11] = '{V, -1, 1'b0, 1'b1, 24'h000000, V, H, 1'b1, 0, 1'b0, 0};
    tbl[12] = '{V, -1, 1'b0, 1'b1, 24'hFFFFFF, V, H, 1'b1, 0, 1'b0, 0};

    resetn = 1'b0;
    pix_en = 1'b0;
    vga_hs = 1'b1;
    vga_vs = 1'b1;
    vga_blank_n = 1'b0;
    vga_rgb = 24'h0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {pix_valid, pix_x, pix_y, pix_rgb, frame_done, line_px, frame_lines, locked, timing_err}, 0);
    resetn = 1'b1;

    @(negedge clk);
    vga_blank_n = 1'b1;
    vga_rgb = 24'h123456;
    pix_en = 1'b1;
    @(negedge clk);
    pix_en = 1'b0;
    vga_blank_n = 1'b0;
    chk("lat_cycle1_valid", pix_valid, 0);
    @(negedge clk);
    chk("lat_cycle2_valid", pix_valid, 1);
    chk("lat_cycle2_data", {pix_x, pix_y, pix_rgb}, {10'd0, 10'd0, 24'h123456});
    @(negedge clk);
    chk("lat_pulse_end", pix_valid, 0);
    chk("lat_hold_rgb", pix_rgb, 24'h123456);

    line(0, 0, 0, 1'b0, 24'h0);
    trk = 1'b1;
    line(0, 1, 0, 1'b0, 24'h0);
    chk("pre_fd", 128'(fd_cnt), 1);
    chk("pre_locked", locked, 0);

    for (int e = 0; e < 13; e++) begin
      fd0 = fd_cnt;
      te0 = te_cnt;
      frame(tbl[e].nl, tbl[e].sh, tbl[e].simul, tbl[e].solid, tbl[e].col);
      chk($sformatf("f%0d_fd", e), 128'(fd_cnt - fd0), 1);
      chk($sformatf("f%0d_frame_lines", e), fl_at_fd, 128'(tbl[e].fl));
      chk($sformatf("f%0d_line_px", e), line_px, 128'(tbl[e].lpx));
      chk($sformatf("f%0d_locked", e), lk_at_fd, tbl[e].lk);
      chk($sformatf("f%0d_te_count", e), 128'(te_cnt - te0), 128'(tbl[e].te));
      chk($sformatf("f%0d_te_at_fd", e), te_at_fd, tbl[e].tefd);
      if (tbl[e].te != 0) chk($sformatf("f%0d_te_line_px", e), te_lpx, 128'(tbl[e].telpx));
      chk($sformatf("f%0d_last_xy", e), {lx, ly}, {W'(H - 1), W'(tbl[e].nl - 1)});
      cmp_pixels();
`ifdef VGA_RX_CRC_EN
      if (tbl[e].solid) chk($sformatf("f%0d_crc", e), crc_at_fd, crc_ref(tbl[e].col, H * V));
`endif
    end

    line(0, 0, 0, 1'b0, 24'h0);
    for (int i = 0; i < 5; i++) line(H, 0, i, 1'b0, 24'h0);
    @(posedge clk);
    #2 resetn = 1'b0;
    trk = 1'b0;
    @(negedge clk);
    chk("mid_reset_outputs", {pix_valid, pix_x, pix_y, pix_rgb, frame_done, line_px, frame_lines, locked, timing_err}, 0);
    @(negedge clk);
    resetn = 1'b1;
    fd0 = fd_cnt;
    for (int i = 5; i < V; i++) line(H, 0, i, 1'b0, 24'h0);
    line(0, 0, 0, 1'b0, 24'h0);
    line(0, 1, 0, 1'b0, 24'h0);
    line(0, 1, 0, 1'b0, 24'h0);
    chk("rst_vs1_fd", 128'(fd_cnt - fd0), 1);
    chk("rst_vs1_locked", lk_at_fd, 0);
    exp_n = got_n;
    rd = got_n;
    trk = 1'b1;
    frame(V, -1, 1'b0, 1'b0, 24'h0);
    chk("rst_vs2_locked", lk_at_fd, 1);
    chk("rst_vs2_frame_lines", fl_at_fd, 128'(V));
    cmp_pixels();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
